// File: rtl/gate_sweep_pkg.sv
// Shared definitions for the gate truth-table sweeper.
// Holds the gate mode encodings and the FSM state type.
// Also holds the reference gate function used by the checker.
package gate_sweep_pkg;

  localparam logic [2:0] MODE_AND  = 3'b000;
  localparam logic [2:0] MODE_OR   = 3'b001;
  localparam logic [2:0] MODE_NAND = 3'b010;
  localparam logic [2:0] MODE_NOR  = 3'b011;
  localparam logic [2:0] MODE_XOR  = 3'b100;
  localparam logic [2:0] MODE_XNOR = 3'b101;

  localparam int MAX_INPUTS = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  // Codes 11x do not name a gate.
  function automatic logic mode_is_valid(input logic [2:0] mode);
    return (mode < 3'b110);
  endfunction

  // Expected gate output over the low n bits of vec; the upper bits are ignored.
  function automatic logic ref_gate(input logic [2:0] mode,
                                    input logic [MAX_INPUTS-1:0] vec,
                                    input int n);
    logic all1;
    logic any1;
    logic par;
    logic y;
    all1 = 1'b1;
    any1 = 1'b0;
    par  = 1'b0;
    for (int i = 0; i < MAX_INPUTS; i++) begin
      if (i < n) begin
        all1 = all1 & vec[i];
        any1 = any1 | vec[i];
        par  = par ^ vec[i];
      end
    end
    case (mode)
      MODE_AND:  y = all1;
      MODE_OR:   y = any1;
      MODE_NAND: y = ~all1;
      MODE_NOR:  y = ~any1;
      MODE_XOR:  y = par;
      MODE_XNOR: y = ~par;
      default:   y = 1'b0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/gate_sweep_checker_ref.sv
// Combinational N-input reference gate: (mode, vec) -> expected y, mode valid.
// Latency: zero cycles, purely combinational.
// Backpressure: none; the output follows the inputs continuously.
module gate_ref_model
  import gate_sweep_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [2:0]   mode,
  input  logic [N-1:0] vec,
  output logic         y,
  output logic         valid
);

  logic [MAX_INPUTS-1:0] vec_ext;

  // Zero-extend the vector to the width the shared function expects.
  always_comb begin
    vec_ext        = '0;
    vec_ext[N-1:0] = vec;
  end

  assign y     = ref_gate(mode, vec_ext, N);
  assign valid = mode_is_valid(mode);

endmodule

// File: rtl/gate_sweep_checker.sv
// Sweeps all 2^N input vectors onto a gate under test and checks each against the reference.
// Latency: each vector held HOLD_CYCLES cycles; done pulses 2^N*HOLD_CYCLES cycles after start.
// Backpressure: none; start is ignored unless idle, results are held until the next start.
module gate_sweep_checker
  import gate_sweep_pkg::*;
#(
  parameter int N           = 2,
  parameter int HOLD_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   mode,
  output logic [N-1:0] dut_in,
  input  logic         dut_out,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic         mode_err,
  output logic [N:0]   err_count,
  output logic         fail_valid,
  output logic [N-1:0] first_fail_vec
);

  localparam int DW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(HOLD_CYCLES - 1);

  state_t         state_q, state_d;
  logic [DW-1:0]  dwell_q, dwell_d;
  logic [2:0]     mode_q, mode_d;
  logic [N-1:0]   dut_in_d;
  logic           pass_d, mode_err_d, fail_valid_d;
  logic [N:0]     err_count_d;
  logic [N-1:0]   first_fail_vec_d;
  logic [2:0]     mode_sel;
  logic           ref_y, ref_valid, mismatch;

  // While idle the reference judges the incoming mode; afterwards the latched copy.
  assign mode_sel = (state_q == ST_IDLE) ? mode : mode_q;

  gate_ref_model #(.N(N)) u_ref (
    .mode  (mode_sel),
    .vec   (dut_in),
    .y     (ref_y),
    .valid (ref_valid)
  );

  assign mismatch = (dut_out != ref_y);
  assign busy     = (state_q == ST_DRIVE);
  assign done     = (state_q == ST_FINISH);

  // Next-state and result update; every register holds unless a case changes it.
  always_comb begin
    state_d          = state_q;
    dwell_d          = dwell_q;
    mode_d           = mode_q;
    dut_in_d         = dut_in;
    pass_d           = pass;
    mode_err_d       = mode_err;
    err_count_d      = err_count;
    fail_valid_d     = fail_valid;
    first_fail_vec_d = first_fail_vec;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pass_d           = 1'b0;
          err_count_d      = '0;
          fail_valid_d     = 1'b0;
          first_fail_vec_d = '0;
          if (ref_valid) begin
            mode_d     = mode;
            dut_in_d   = '0;
            dwell_d    = '0;
            mode_err_d = 1'b0;
            state_d    = ST_DRIVE;
          end else begin
            // Invalid gate code: report immediately, drive nothing.
            mode_err_d = 1'b1;
            state_d    = ST_FINISH;
          end
        end
      end
      ST_DRIVE: begin
        if (dwell_q == DWELL_LAST) begin
          if (mismatch) begin
            err_count_d = err_count + 1'b1;
            if (!fail_valid) begin
              fail_valid_d     = 1'b1;
              first_fail_vec_d = dut_in;
            end
          end
          // A mismatch on the last vector still counts before the verdict.
          if (&dut_in) begin
            pass_d  = (err_count_d == '0);
            state_d = ST_FINISH;
          end else begin
            dut_in_d = dut_in + 1'b1;
            dwell_d  = '0;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State, counters and held results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      dwell_q        <= '0;
      mode_q         <= '0;
      dut_in         <= '0;
      pass           <= 1'b0;
      mode_err       <= 1'b0;
      err_count      <= '0;
      fail_valid     <= 1'b0;
      first_fail_vec <= '0;
    end else begin
      state_q        <= state_d;
      dwell_q        <= dwell_d;
      mode_q         <= mode_d;
      dut_in         <= dut_in_d;
      pass           <= pass_d;
      mode_err       <= mode_err_d;
      err_count      <= err_count_d;
      fail_valid     <= fail_valid_d;
      first_fail_vec <= first_fail_vec_d;
    end
  end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: N=2/H=4 instance plus an N=3/H=1 instance.
// Expected sweep results are queued at start and compared when done pulses.
// The gate under test is modelled here, selectable as correct NOR or stuck-at-0.
module tb_gate_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start;
  logic [2:0] mode;
  logic [1:0] dut_in;
  logic       dut_out;
  logic       busy, done, pass, mode_err, fail_valid;
  logic [2:0] err_count;
  logic [1:0] first_fail_vec;

  logic       start3;
  logic [2:0] mode3;
  logic [2:0] dut_in3;
  logic       dut_out3;
  logic       busy3, done3, pass3, mode_err3, fail_valid3;
  logic [3:0] err_count3;
  logic [2:0] first_fail_vec3;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int gut_kind = 0;

  typedef struct {
    logic [2:0] err;
    logic       pass;
    logic       mode_err;
    logic       fv;
    logic [1:0] ffv;
    int         lat;
  } exp_t;

  exp_t sb[$];

  gate_sweep_checker #(.N(2), .HOLD_CYCLES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done),
    .pass(pass), .mode_err(mode_err), .err_count(err_count),
    .fail_valid(fail_valid), .first_fail_vec(first_fail_vec)
  );

  gate_sweep_checker #(.N(3), .HOLD_CYCLES(1)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .mode(mode3),
    .dut_in(dut_in3), .dut_out(dut_out3), .busy(busy3), .done(done3),
    .pass(pass3), .mode_err(mode_err3), .err_count(err_count3),
    .fail_valid(fail_valid3), .first_fail_vec(first_fail_vec3)
  );

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic gut_model(input int kind, input logic [1:0] v);
    return (kind == 1) ? 1'b0 : ~(v[0] | v[1]);
  endfunction

  always_comb dut_out  = gut_model(gut_kind, dut_in);
  always_comb dut_out3 = ~(dut_in3[0] & dut_in3[1] & dut_in3[2]);

  function automatic logic model_gate(input logic [2:0] m, input logic [1:0] v);
    logic y;
    case (m)
      3'b000:  y = v[0] & v[1];
      3'b001:  y = v[0] | v[1];
      3'b010:  y = ~(v[0] & v[1]);
      3'b011:  y = ~(v[0] | v[1]);
      3'b100:  y = v[0] ^ v[1];
      default: y = ~(v[0] ^ v[1]);
    endcase
    return y;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_expect(input logic [2:0] m);
    exp_t e;
    logic [1:0] v;
    e.err = 0; e.pass = 0; e.mode_err = 0; e.fv = 0; e.ffv = 0; e.lat = 0;
    if (m >= 3'b110) begin
      e.mode_err = 1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        v = i[1:0];
        if (gut_model(gut_kind, v) != model_gate(m, v)) begin
          e.err = e.err + 1'b1;
          if (!e.fv) begin
            e.fv  = 1;
            e.ffv = v;
          end
        end
      end
      e.pass = (e.err == 0);
      e.lat  = 16;
    end
    sb.push_back(e);
  endtask

  task automatic run_sweep(input logic [2:0] m, input bit disturb, input bit chk_vec);
    int   k;
    int   j;
    bit   seen;
    exp_t e;
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    push_expect(m);
    @(posedge clk);
    #1 start = 1'b0;
    k    = cyc;
    seen = 0;
    for (int it = 0; it < 100 && !seen; it++) begin
      @(negedge clk);
      j = cyc - k;
      if (disturb && j == 5) begin
        start = 1'b1;
        mode  = 3'b100;
      end
      if (disturb && j == 6) begin
        start = 1'b0;
        mode  = 3'b001;
      end
      if (chk_vec && !done && (j % 4 == 0)) check_eq("vec_seq", dut_in, j / 4);
      if (chk_vec && j == 1) check_eq("busy_mid", busy, 1);
      if (done) begin
        seen = 1;
        e = sb.pop_front();
        check_eq("done_latency", j, e.lat);
        check_eq("err_count", err_count, e.err);
        check_eq("pass", pass, e.pass);
        check_eq("mode_err", mode_err, e.mode_err);
        check_eq("fail_valid", fail_valid, e.fv);
        check_eq("first_fail_vec", first_fail_vec, e.ffv);
      end
    end
    if (!seen) begin
      check_eq("done_timeout", 0, 1);
      if (sb.size() > 0) e = sb.pop_front();
    end else begin
      @(negedge clk);
      check_eq("done_one_cycle", done, 0);
      check_eq("busy_after", busy, 0);
      check_eq("pass_held", pass, e.pass);
    end
  endtask

  initial begin
    int k3;
    bit seen3;
    rst_n = 1'b0; start = 1'b0; mode = 3'b000;
    start3 = 1'b0; mode3 = 3'b000;
    repeat (3) @(negedge clk);
    check_eq("rst_dut_in", dut_in, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_pass", pass, 0);
    check_eq("rst_mode_err", mode_err, 0);
    check_eq("rst_err_count", err_count, 0);
    check_eq("rst_fail_valid", fail_valid, 0);
    check_eq("rst_first_fail", first_fail_vec, 0);
    check_eq("rst_dut_in3", dut_in3, 0);
    rst_n = 1'b1;

    // Correct NOR gate, NOR mode.
    gut_kind = 0;
    run_sweep(3'b011, 0, 1);
    check_eq("dut_in_hold", dut_in, 3);
    // Stuck-at-0 gate.
    gut_kind = 1;
    run_sweep(3'b011, 0, 0);
    // XOR reference against a NOR gate.
    gut_kind = 0;
    run_sweep(3'b100, 0, 0);
    // Invalid mode.
    run_sweep(3'b110, 0, 0);
    check_eq("inv_busy", busy, 0);
    // Start and mode disturbed mid-sweep.
    run_sweep(3'b011, 1, 1);

    // Asynchronous reset in the middle of vector 10.
    @(negedge clk);
    mode = 3'b011; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int it = 0; it < 40 && dut_in != 2'b10; it++) @(negedge clk);
    check_eq("reach_vec2", dut_in, 2);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_dut_in", dut_in, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_done", done, 0);
    check_eq("arst_err_count", err_count, 0);
    check_eq("arst_fail_valid", fail_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(3'b011, 0, 1);

    // N=3, H=1 with a NAND gate.
    @(negedge clk);
    mode3 = 3'b010; start3 = 1'b1;
    @(posedge clk);
    #1 start3 = 1'b0;
    k3 = cyc;
    seen3 = 0;
    for (int it = 0; it < 50 && !seen3; it++) begin
      @(negedge clk);
      if (done3) begin
        seen3 = 1;
        check_eq("n3_latency", cyc - k3, 8);
        check_eq("n3_pass", pass3, 1);
        check_eq("n3_err_count", err_count3, 0);
        check_eq("n3_fail_valid", fail_valid3, 0);
        check_eq("n3_dut_in", dut_in3, 7);
        check_eq("n3_mode_err", mode_err3, 0);
      end
    end
    if (!seen3) check_eq("n3_done_timeout", 0, 1);
    check_eq("n3_busy3_end", busy3, 0);
    check_eq("n3_first_fail", first_fail_vec3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
